dispatcher: RTL

//  Transmit side of the reservation-station/LSB issue interface. Accepts one decoded instruction per cycle from the

---
 rtl/dispatcher.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dispatcher.sv
// Issue-side dispatcher: one-entry holding stage between the decoder and the RS/LSB, with ROB allocation and rename.
// Optional DISPATCH_PERF_EN adds issue / ROB-stall / unit-stall event counters.
module dispatcher #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,

    input  logic                dec_valid,
    input  logic                dec_is_ls,
    input  logic [OPENUM_W-1:0] dec_openum,
    input  logic [REG_W-1:0]    dec_rd,
    input  logic [REG_W-1:0]    dec_rs1,
    input  logic [REG_W-1:0]    dec_rs2,
    input  logic [DATA_W-1:0]   dec_imm,
    input  logic [ADDR_W-1:0]   dec_pc,
    output logic                ready_to_decoder,

    output logic [REG_W-1:0]    rf_rs1_idx,
    output logic [REG_W-1:0]    rf_rs2_idx,
    input  logic [ROB_ID_W-1:0] rf_Q1,
    input  logic [ROB_ID_W-1:0] rf_Q2,
    input  logic [DATA_W-1:0]   rf_V1,
    input  logic [DATA_W-1:0]   rf_V2,

    input  logic                rob_Q1_ready,
    input  logic                rob_Q2_ready,
    input  logic [DATA_W-1:0]   rob_V1,
    input  logic [DATA_W-1:0]   rob_V2,
    input  logic                rob_full,
    input  logic [ROB_ID_W-1:0] rob_next_id,
    output logic                rob_alloc_en,
    output logic [REG_W-1:0]    rob_alloc_rd,
    output logic [OPENUM_W-1:0] rob_alloc_openum,
    output logic [ADDR_W-1:0]   rob_alloc_pc,

    output logic                rename_en,
    output logic [REG_W-1:0]    rename_rd,
    output logic [ROB_ID_W-1:0] rename_rob_id,

    input  logic                rs_full,
    input  logic                lsb_full,
    output logic                enable_to_rs,
    output logic                enable_to_lsb,
    output logic [OPENUM_W-1:0] openum_out,
    output logic [DATA_W-1:0]   V1_out,
    output logic [DATA_W-1:0]   V2_out,
    output logic [ROB_ID_W-1:0] Q1_out,
    output logic [ROB_ID_W-1:0] Q2_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [DATA_W-1:0]   imm_out,
    output logic [ROB_ID_W-1:0] rob_id_out,

    input  logic                valid_arith_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_arith_cdb,
    input  logic [DATA_W-1:0]   result_arith_cdb,
    input  logic                valid_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_ls_cdb,
    input  logic [DATA_W-1:0]   result_ls_cdb,

`ifdef DISPATCH_PERF_EN
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall_rob,
    output logic [31:0]         perf_stall_unit,
`endif
    input  logic                misbranch_flag
);

    // state    | meaning
    // ST_EMPTY | holding stage free, decoder may push
    // ST_HELD  | one decoded instruction waiting to issue
    typedef enum logic {ST_EMPTY, ST_HELD} state_t;

    localparam logic [ROB_ID_W-1:0] ZERO_ROB   = '0;
    localparam logic [OPENUM_W-1:0] OPENUM_NOP = '0;

    state_t              state, state_next;
    logic                h_is_ls;
    logic [OPENUM_W-1:0] h_openum;
    logic [REG_W-1:0]    h_rd, h_rs1, h_rs2;
    logic [DATA_W-1:0]   h_imm;
    logic [ADDR_W-1:0]   h_pc;

    logic                issue, accept, unit_full;
    logic [ROB_ID_W-1:0] q1_res, q2_res;
    logic [DATA_W-1:0]   v1_res, v2_res;

    function automatic void resolve(
        input  logic [REG_W-1:0]    src,
        input  logic [ROB_ID_W-1:0] rf_q,
        input  logic [DATA_W-1:0]   rf_v,
        input  logic                rob_rdy,
        input  logic [DATA_W-1:0]   rob_v,
        output logic [ROB_ID_W-1:0] q,
        output logic [DATA_W-1:0]   v
    );
        q = ZERO_ROB;
        v = '0;
        if (src != '0) begin
            if (rf_q == ZERO_ROB)
                v = rf_v;
            else if (rob_rdy)
                v = rob_v;
            else if (valid_arith_cdb && rob_id_arith_cdb == rf_q)
                v = result_arith_cdb;
            else if (valid_ls_cdb && rob_id_ls_cdb == rf_q)
                v = result_ls_cdb;
            else
                q = rf_q;
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next       = state;
        issue            = 1'b0;
        accept           = 1'b0;
        ready_to_decoder = 1'b0;
        unit_full        = h_is_ls ? lsb_full : rs_full;
        if (rdy && misbranch_flag) begin
            state_next = ST_EMPTY;
        end else if (rdy) begin
            issue            = (state == ST_HELD) && !rob_full && !unit_full;
            ready_to_decoder = (state == ST_EMPTY) || issue;
            accept           = ready_to_decoder && dec_valid;
            if (accept)
                state_next = ST_HELD;
            else if (issue)
                state_next = ST_EMPTY;
        end
    end

    always_comb begin
        resolve(h_rs1, rf_Q1, rf_V1, rob_Q1_ready, rob_V1, q1_res, v1_res);
        resolve(h_rs2, rf_Q2, rf_V2, rob_Q2_ready, rob_V2, q2_res, v2_res);
    end

    assign rf_rs1_idx       = h_rs1;
    assign rf_rs2_idx       = h_rs2;
    assign rob_alloc_en     = issue;
    assign rob_alloc_rd     = h_rd;
    assign rob_alloc_openum = h_openum;
    assign rob_alloc_pc     = h_pc;
    assign rename_en        = issue && (h_rd != '0);
    assign rename_rd        = h_rd;
    assign rename_rob_id    = rob_next_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_is_ls  <= 1'b0;
            h_openum <= OPENUM_NOP;
            h_rd     <= '0;
            h_rs1    <= '0;
            h_rs2    <= '0;
            h_imm    <= '0;
            h_pc     <= '0;
        end else if (accept) begin
            h_is_ls  <= dec_is_ls;
            h_openum <= dec_openum;
            h_rd     <= dec_rd;
            h_rs1    <= dec_rs1;
            h_rs2    <= dec_rs2;
            h_imm    <= dec_imm;
            h_pc     <= dec_pc;
        end
    end

    // Issue bundle: operand fields keep their last values between issues, only the opcode drops to NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_to_rs  <= 1'b0;
            enable_to_lsb <= 1'b0;
            openum_out    <= OPENUM_NOP;
            V1_out        <= '0;
            V2_out        <= '0;
            Q1_out        <= ZERO_ROB;
            Q2_out        <= ZERO_ROB;
            pc_out        <= '0;
            imm_out       <= '0;
            rob_id_out    <= ZERO_ROB;
        end else if (rdy) begin
            if (issue) begin
                enable_to_rs  <= !h_is_ls;
                enable_to_lsb <= h_is_ls;
                openum_out    <= h_openum;
                V1_out        <= v1_res;
                V2_out        <= v2_res;
                Q1_out        <= q1_res;
                Q2_out        <= q2_res;
                pc_out        <= h_pc;
                imm_out       <= h_imm;
                rob_id_out    <= rob_next_id;
            end else begin
                enable_to_rs  <= 1'b0;
                enable_to_lsb <= 1'b0;
                openum_out    <= OPENUM_NOP;
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic stall_rob, stall_unit;
    assign stall_rob  = rdy && !misbranch_flag && (state == ST_HELD) && rob_full;
    assign stall_unit = rdy && !misbranch_flag && (state == ST_HELD) && !rob_full && unit_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued     <= '0;
            perf_stall_rob  <= '0;
            perf_stall_unit <= '0;
        end else begin
            if (issue)      perf_issued     <= perf_issued + 32'd1;
            if (stall_rob)  perf_stall_rob  <= perf_stall_rob + 32'd1;
            if (stall_unit) perf_stall_unit <= perf_stall_unit + 32'd1;
        end
    end
`endif

endmodule
